// File: rtl/seq_arith_pkg.sv
// Shared types and defaults for the bit-serial
// sequential-arithmetic blocks.
package seq_arith_pkg;

  localparam int DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register; emits from
// the MSB or LSB end with zero fill behind.
import seq_arith_pkg::*;

module piso_shift_reg #(
  parameter int WIDTH     = DEF_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             q_bit
);

  logic [WIDTH-1:0] q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (shift) begin
      if (MSB_FIRST) q <= q << 1;
      else           q <= q >> 1;
    end
  end

  assign q_bit = MSB_FIRST ? q[WIDTH-1] : q[0];

endmodule

// File: rtl/serial_operand_tx.sv
// Bit-serial operand-pair transmitter with
// first/last framing and a done pulse.
import seq_arith_pkg::*;

module serial_operand_tx #(
  parameter int WIDTH     = DEF_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ld_valid,
  output logic             ld_ready,
  output logic             ser_a,
  output logic             ser_b,
  output logic             ser_valid,
  output logic             ser_first,
  output logic             ser_last,
  input  logic             ser_ready,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t        state;
  state_t        nxt;
  logic [CW-1:0] cnt;
  logic          load;
  logic          xfer;
  logic          qa;
  logic          qb;

  assign load = ld_valid & (state == ST_IDLE);
  assign xfer = ser_ready & (state == ST_SHIFT);

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (1'b1)
      (state == ST_IDLE):  if (ld_valid) nxt = ST_SHIFT;
      (state == ST_SHIFT): if (xfer && cnt == LAST) nxt = ST_DONE;
      (state == ST_DONE):  nxt = ST_IDLE;
      default:             nxt = ST_IDLE;
    endcase
  end

  // Counter parks at zero between frames.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (xfer) begin
      if (cnt == LAST) cnt <= '0;
      else             cnt <= cnt + CW'(1);
    end
  end

  piso_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_sr_a (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (xfer),
    .d     (a),
    .q_bit (qa)
  );

  piso_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_sr_b (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (xfer),
    .d     (b),
    .q_bit (qb)
  );

  assign ld_ready  = (state == ST_IDLE);
  assign ser_valid = (state == ST_SHIFT);
  assign busy      = (state == ST_SHIFT) | (state == ST_DONE);
  assign done      = (state == ST_DONE);
  assign ser_a     = ser_valid & qa;
  assign ser_b     = ser_valid & qb;
  assign ser_first = ser_valid & (cnt == '0);
  assign ser_last  = ser_valid & (cnt == LAST);

endmodule

// File: tb/tb_serial_operand_tx.sv
// Scoreboard bench driving an MSB-first and an
// LSB-first transmitter in lockstep.
module tb_serial_operand_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_valid;
  logic        ser_ready;
  logic [31:0] a;
  logic [31:0] b;

  logic m_ldr, m_sa, m_sb, m_sv, m_sf, m_sl, m_busy, m_done;
  logic l_ldr, l_sa, l_sb, l_sv, l_sf, l_sl, l_busy, l_done;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] qm[$];
  logic [3:0] ql[$];

  always #5 clk = ~clk;

  serial_operand_tx #(.WIDTH(32), .MSB_FIRST(1'b1)) u_msb (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .ld_valid  (ld_valid),
    .ld_ready  (m_ldr),
    .ser_a     (m_sa),
    .ser_b     (m_sb),
    .ser_valid (m_sv),
    .ser_first (m_sf),
    .ser_last  (m_sl),
    .ser_ready (ser_ready),
    .busy      (m_busy),
    .done      (m_done)
  );

  serial_operand_tx #(.WIDTH(32), .MSB_FIRST(1'b0)) u_lsb (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .ld_valid  (ld_valid),
    .ld_ready  (l_ldr),
    .ser_a     (l_sa),
    .ser_b     (l_sb),
    .ser_valid (l_sv),
    .ser_first (l_sf),
    .ser_last  (l_sl),
    .ser_ready (ser_ready),
    .busy      (l_busy),
    .done      (l_done)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // Expected beat = {first, last, a_bit, b_bit}.
  task automatic push(input logic [31:0] va,
                      input logic [31:0] vb);
    for (int i = 0; i < 32; i++) begin
      qm.push_back({i == 0, i == 31,
                    va[31-i], vb[31-i]});
      ql.push_back({i == 0, i == 31,
                    va[i], vb[i]});
    end
  endtask

  task automatic frame(input logic [31:0] va,
                       input logic [31:0] vb,
                       input int s0b, input int s0l,
                       input int s1b, input int s1l,
                       input bit chg,
                       input int abort);
    int beat = 0;
    int st   = 0;
    int cyc  = 0;
    int vcyc = 0;
    int need;
    chk("ld_ready_idle", {30'd0, m_ldr, l_ldr}, 2'b11);
    a = va;
    b = vb;
    ld_valid = 1'b1;
    push(va, vb);
    @(negedge clk);
    if (!chg) ld_valid = 1'b0;
    while (beat < 32 && cyc < 200) begin
      chk("msb_beat",
          {27'd0, m_sv, m_sf, m_sl, m_sa, m_sb},
          {27'd0, 1'b1, qm[0]});
      chk("lsb_beat",
          {27'd0, l_sv, l_sf, l_sl, l_sa, l_sb},
          {27'd0, 1'b1, ql[0]});
      chk("shift_ctl",
          {26'd0, m_ldr, l_ldr, m_busy, l_busy,
           m_done, l_done}, 6'b001100);
      vcyc++;
      if (beat == abort) begin
        rst = 1'b0;
        ld_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("abort",
            {24'd0, m_sv, m_busy, m_done, m_ldr,
             l_sv, l_busy, l_done, l_ldr},
            8'b0001_0001);
        qm.delete();
        ql.delete();
        return;
      end
      need = (beat == s0b) ? s0l :
             (beat == s1b) ? s1l : 0;
      if (st < need) begin
        ser_ready = 1'b0;
        st++;
      end else begin
        ser_ready = 1'b1;
        st = 0;
        void'(qm.pop_front());
        void'(ql.pop_front());
        beat++;
      end
      if (chg) a = $urandom;
      @(negedge clk);
      cyc++;
    end
    chk("beats", beat, 32);
    chk("valid_cycles", vcyc, 32 + s0l + s1l);
    chk("done_state",
        {24'd0, m_done, l_done, m_busy, l_busy,
         m_sv, l_sv, m_ldr, l_ldr}, 8'b1111_0000);
    ld_valid = 1'b0;
    ser_ready = 1'b1;
    @(negedge clk);
    chk("back_idle",
        {24'd0, m_done, l_done, m_busy, l_busy,
         m_sv, l_sv, m_ldr, l_ldr}, 8'b0000_0011);
  endtask

  initial begin
    rst = 1'b0;
    ld_valid = 1'b0;
    ser_ready = 1'b1;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    chk("reset_ctl",
        {24'd0, m_done, l_done, m_busy, l_busy,
         m_sv, l_sv, m_ldr, l_ldr}, 8'b0000_0011);
    chk("reset_data",
        {24'd0, m_sa, m_sb, m_sf, m_sl,
         l_sa, l_sb, l_sf, l_sl}, 8'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_ready_noeffect",
        {30'd0, m_sv, l_sv}, 2'b00);

    frame(32'd50, 32'd50, -1, 0, -1, 0, 1'b0, -1);
    frame(32'h8000_0001, 32'h7FFF_FFFE,
          -1, 0, -1, 0, 1'b0, -1);
    frame(32'h8000_0001, 32'h7FFF_FFFE,
          0, 3, 15, 5, 1'b0, -1);
    frame(32'h0000_0001, 32'h8000_0000,
          -1, 0, -1, 0, 1'b0, -1);
    frame(32'h1234_5678, 32'hCAFE_F00D,
          -1, 0, -1, 0, 1'b1, -1);
    frame(32'hFFFF_0000, 32'h00FF_00FF,
          -1, 0, -1, 0, 1'b0, 10);
    frame(32'd3, 32'd1, -1, 0, -1, 0, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_operand_tx.md
Name: serial_operand_tx

Overview:
- Bit-serial transmitter for operand pairs: loads two WIDTH-bit words in parallel and emits them one bit-pair per accepted cycle, with first/last framing.
- Drives the bit-serial input side of the sequential comparator datapath and any other bit-serial consumer in the COA sequential-arithmetic set.
- Valid/ready handshake on both the parallel load side and the serial side; downstream may stall at any bit.

Parameters:
- WIDTH, 32, operand width in bits (>= 2).
- MSB_FIRST, 1, 1 = emit bit WIDTH-1 first (comparator order); 0 = emit bit 0 first.

Ports:
- clk  in  1  sole clock, all state updates on rising edge.
- rst  in  1  synchronous, active-low reset (sampled on clk rising edge while 0).
- a  in  WIDTH  operand A, sampled only on a load transfer.
- b  in  WIDTH  operand B, sampled only on a load transfer.
- ld_valid  in  1  load request.
- ld_ready  out  1  block can accept a load (high only in IDLE).
- ser_a  out  1  current bit of A.
- ser_b  out  1  current bit of B.
- ser_valid  out  1  ser_a/ser_b/ser_first/ser_last are valid.
- ser_first  out  1  current bit is the first of the frame.
- ser_last  out  1  current bit is the last of the frame.
- ser_ready  in  1  consumer accepts the current bit this cycle.
- busy  out  1  frame in progress (SHIFT or DONE).
- done  out  1  one-cycle pulse after the last bit is accepted.

Behaviour:
- States: IDLE, SHIFT, DONE. All outputs are decoded from registered state, shift registers and counter; no combinational path from ser_ready or ld_valid to any output.
- Reset (rst=0 at an edge): state=IDLE, shift registers=0, cnt=0. After reset: ld_ready=1; ser_valid, ser_a, ser_b, ser_first, ser_last, busy and done are 0.
- Reset asserted mid-frame aborts the frame at that edge. No done pulse is produced and the partial frame is discarded.
- IDLE: ld_ready=1. Load transfer = ld_valid & ld_ready at an edge. It captures a and b into shift registers, clears cnt and moves to SHIFT. ld_valid low: stay in IDLE.
- SHIFT: ser_valid=1, busy=1, ld_ready=0.
  - ser_a/ser_b = shreg MSB when MSB_FIRST=1, LSB otherwise.
  - ser_first = (cnt==0); ser_last = (cnt==WIDTH-1).
- Bit transfer = ser_valid & ser_ready at an edge. It shifts both registers by one toward the emitting end (zero fill) and increments cnt.
- ser_ready=0 (stall): all serial outputs hold unchanged and cnt holds, for any number of cycles.
- Transfer while ser_last=1 -> DONE; cnt returns to 0.
- DONE: done=1, busy=1, ser_valid=0, ld_ready=0, for exactly one cycle, then IDLE unconditionally.
- ld_valid while not in IDLE is ignored. a and b may change freely except at the load edge.
- Counter: width $clog2(WIDTH); no wrap within a frame.
- Latency, with load at edge N and ser_ready held 1:
  - first bit valid in the cycle after N;
  - last bit valid WIDTH cycles after N;
  - done high WIDTH+1 cycles after N;
  - ld_ready high again WIDTH+2 cycles after N.
- Throughput: one frame per WIDTH+2 cycles minimum.
- Simultaneous events:
  - Reset wins over any transfer.
  - ser_ready high in DONE/IDLE has no effect.

Decomposition:
- Shared package seq_arith_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2;
  - default WIDTH 32.
- Sub-module piso_shift_reg (WIDTH, MSB_FIRST; ports clk, rst, load, shift, d, q_bit), instantiated twice, for A and B.
- FSM, counter and framing stay in serial_operand_tx.

Test Plan:
1. Reset then load a=50, b=50, MSB_FIRST=1, ser_ready=1 -> 32 beats.
   - Bit pairs equal across all beats; set bits match 50 (0x32) at beats 26, 27, 30.
   - ser_first only on beat 0, ser_last only on beat 31.
   - done pulses one cycle after beat 31; ld_ready returns the cycle after that.
2. Load a=0x80000001, b=0x7FFFFFFE -> beat 0: ser_a=1, ser_b=0; beat 31: ser_a=1, ser_b=0; beats 1-30: ser_a=0, ser_b=1.
3. Same load as scenario 2, with ser_ready low for 3 cycles at beat 0 and 5 cycles at beat 15.
   - Outputs frozen during each stall; cnt unchanged.
   - Total frame length 32+8 valid cycles; bit sequence identical to scenario 2.
4. MSB_FIRST=0, load a=0x00000001, b=0x80000000 -> beat 0: ser_a=1, ser_b=0; beat 31: ser_a=0, ser_b=1.
5. ld_valid held 1 with a changing every cycle during a frame -> only the value at the load edge is emitted; exactly one frame per done pulse; ld_ready=0 throughout SHIFT/DONE.
6. rst=0 at beat 10 of a frame -> next cycle: ser_valid=0, busy=0, done=0, ld_ready=1.
   - A new load of a=3, b=1 then produces a clean frame starting with ser_first=1.
